// File: rtl/vx_multicore_mem_arb.sv
// ---------------------------------------------------------------------------
// vx_multicore_mem_arb
//
// Merges NUM_REQS core memory channels onto one memory port and routes the
// memory responses back to the issuing channel.
//
// Request path: round-robin arbiter feeding a single output register stage
// (one cycle of latency). The channel index is appended to the tag LSBs so
// that responses can be routed back. Reads are throttled so that at most
// MAX_PENDING reads are outstanding; writes are never throttled and expect
// no response.
//
// Response path: purely combinational demux on the tag LSBs. Responses that
// carry an index with no matching channel are consumed and dropped.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   req_*_in  / req_ready_in   per-channel request bundle (flattened buses)
//   req_*_out / req_ready_out  merged request to memory
//   rsp_*_in  / rsp_ready_in   memory response
//   rsp_*_out / rsp_ready_out  per-channel response (payload broadcast)
//   pending_count              number of outstanding reads
//   busy                       outstanding reads or a held request
// ---------------------------------------------------------------------------
module vx_multicore_mem_arb #(
    parameter int NUM_REQS     = 4,
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 26,
    parameter int TAG_IN_WIDTH = 8,
    parameter int MAX_PENDING  = 16,
    localparam int LOG_REQS      = $clog2(NUM_REQS),
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS,
    localparam int CNT_W         = $clog2(MAX_PENDING + 1),
    localparam int BYTEEN_W      = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [NUM_REQS-1:0]              req_valid_in,
    input  logic [NUM_REQS-1:0]              req_rw_in,
    input  logic [NUM_REQS*BYTEEN_W-1:0]     req_byteen_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
    output logic [NUM_REQS-1:0]              req_ready_in,

    output logic                             req_valid_out,
    output logic                             req_rw_out,
    output logic [BYTEEN_W-1:0]              req_byteen_out,
    output logic [ADDR_WIDTH-1:0]            req_addr_out,
    output logic [DATA_WIDTH-1:0]            req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
    input  logic                             req_ready_out,

    input  logic                             rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]            rsp_data_in,
    input  logic [TAG_OUT_WIDTH-1:0]         rsp_tag_in,
    output logic                             rsp_ready_in,

    output logic [NUM_REQS-1:0]              rsp_valid_out,
    output logic [DATA_WIDTH-1:0]            rsp_data_out,
    output logic [TAG_IN_WIDTH-1:0]          rsp_tag_out,
    input  logic [NUM_REQS-1:0]              rsp_ready_out,

    output logic [CNT_W-1:0]                 pending_count,
    output logic                             busy
);

    // -----------------------------------------------------------------------
    // Per-channel views of the flattened request buses
    // -----------------------------------------------------------------------
    logic [BYTEEN_W-1:0]     byteen_arr [NUM_REQS];
    logic [ADDR_WIDTH-1:0]   addr_arr   [NUM_REQS];
    logic [DATA_WIDTH-1:0]   data_arr   [NUM_REQS];
    logic [TAG_IN_WIDTH-1:0] tag_arr    [NUM_REQS];
    logic [NUM_REQS-1:0]     eligible;

    logic [CNT_W-1:0]        pending_reg;
    logic [CNT_W-1:0]        pending_next;
    logic                    pending_full;

    assign pending_full = (pending_reg == CNT_W'(MAX_PENDING));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_chan
            assign byteen_arr[gi] = req_byteen_in[gi*BYTEEN_W     +: BYTEEN_W];
            assign addr_arr[gi]   = req_addr_in  [gi*ADDR_WIDTH   +: ADDR_WIDTH];
            assign data_arr[gi]   = req_data_in  [gi*DATA_WIDTH   +: DATA_WIDTH];
            assign tag_arr[gi]    = req_tag_in   [gi*TAG_IN_WIDTH +: TAG_IN_WIDTH];
            // A read needs a free slot in the outstanding-read budget.
            assign eligible[gi]   = req_valid_in[gi] & (req_rw_in[gi] | ~pending_full);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin arbiter
    // -----------------------------------------------------------------------
    logic                valid_reg;
    logic                rw_reg;
    logic [BYTEEN_W-1:0] byteen_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [TAG_OUT_WIDTH-1:0] tag_reg;
    logic [LOG_REQS-1:0] rr_ptr_reg;

    logic                grant_valid;
    logic [LOG_REQS-1:0] grant_idx;
    logic [LOG_REQS:0]   cand;
    logic                load_en;
    logic                grant_fire;
    logic                rd_fire;
    logic                rsp_fire;

    // Scan from the farthest candidate (the last winner itself) to the
    // nearest (last winner + 1); the last eligible hit is the nearest one.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQS; k >= 1; k--) begin
            cand = {1'b0, rr_ptr_reg} + (LOG_REQS+1)'(k);
            if (cand >= (LOG_REQS+1)'(NUM_REQS)) begin
                cand = cand - (LOG_REQS+1)'(NUM_REQS);
            end
            if (eligible[cand[LOG_REQS-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[LOG_REQS-1:0];
            end
        end
    end

    // The register accepts a new request when empty or when draining.
    assign load_en    = ~valid_reg | req_ready_out;
    assign grant_fire = reset & load_en & grant_valid;
    assign rd_fire    = grant_fire & ~req_rw_in[grant_idx];

    always_comb begin
        req_ready_in = '0;
        if (grant_fire) begin
            req_ready_in[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_reg  <= 1'b0;
            rr_ptr_reg <= LOG_REQS'(NUM_REQS - 1);
        end else if (load_en) begin
            valid_reg <= grant_valid;
            if (grant_valid) begin
                rr_ptr_reg <= grant_idx;
            end
        end
    end

    // Payload fields only change on a grant, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            rw_reg     <= req_rw_in[grant_idx];
            byteen_reg <= byteen_arr[grant_idx];
            addr_reg   <= addr_arr[grant_idx];
            data_reg   <= data_arr[grant_idx];
            tag_reg    <= {tag_arr[grant_idx], grant_idx};
        end
    end

    assign req_valid_out  = valid_reg;
    assign req_rw_out     = rw_reg;
    assign req_byteen_out = byteen_reg;
    assign req_addr_out   = addr_reg;
    assign req_data_out   = data_reg;
    assign req_tag_out    = tag_reg;

    // -----------------------------------------------------------------------
    // Response demux
    // -----------------------------------------------------------------------
    logic [LOG_REQS-1:0] rsp_idx;
    logic                rsp_idx_ok;

    assign rsp_idx    = rsp_tag_in[LOG_REQS-1:0];
    assign rsp_idx_ok = ({1'b0, rsp_idx} < (LOG_REQS+1)'(NUM_REQS));

    always_comb begin
        rsp_valid_out = '0;
        rsp_ready_in  = 1'b1;   // orphan responses are swallowed
        if (rsp_idx_ok) begin
            rsp_valid_out[rsp_idx] = rsp_valid_in;
            rsp_ready_in           = rsp_ready_out[rsp_idx];
        end
    end

    assign rsp_data_out = rsp_data_in;
    assign rsp_tag_out  = rsp_tag_in[TAG_OUT_WIDTH-1:LOG_REQS];
    assign rsp_fire     = rsp_valid_in & rsp_ready_in;

    // -----------------------------------------------------------------------
    // Outstanding-read counter (saturates at zero; a stray response after a
    // reset cannot underflow it)
    // -----------------------------------------------------------------------
    always_comb begin
        pending_next = pending_reg;
        if (rd_fire && !rsp_fire) begin
            pending_next = pending_reg + CNT_W'(1);
        end else if (!rd_fire && rsp_fire && (pending_reg != '0)) begin
            pending_next = pending_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign pending_count = pending_reg;
    assign busy          = (pending_reg != '0) | valid_reg;

endmodule
